// File: rtl/serial_receiver.sv
// serial_receiver: start/data/stop frame receiver driven by an external bit strobe.
//
// Ports:
//   clock     - single clock; all state changes on the rising edge
//   reset     - asynchronous, active-low reset
//   serialIn  - serial line, idles high
//   step      - bit strobe; serialIn is sampled only on edges where step=1
//   ack       - consumer acknowledge; clears valid
//   clrErr    - clears the sticky frameErr/overrun flags
//   outData   - last good received word
//   valid     - outData holds an unacknowledged word
//   busy      - receiver is inside a frame (DATA or STOP)
//   frameErr  - sticky: a stop bit was sampled low
//   overrun   - sticky: a word was overwritten before it was acknowledged
//
// Parameters:
//   WIDTH     - data bits per frame (2..16)
//   LSB_FIRST - 1: first data bit lands in outData[0]; 0: in outData[WIDTH-1]
module serial_receiver #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serialIn,
  input  logic             step,
  input  logic             ack,
  input  logic             clrErr,
  output logic [WIDTH-1:0] outData,
  output logic             valid,
  output logic             busy,
  output logic             frameErr,
  output logic             overrun
);

  // Counter only has to reach WIDTH-1; it is cleared on entry to STOP so it never wraps.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic             load_s;
  logic             ferr_evt_s;

  // Insert one bit so that after WIDTH shifts the first bit sits at the
  // chosen end of the word.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                 input logic            bit_in);
    logic [WIDTH-1:0] res;
    if (LSB_FIRST) begin
      res = {bit_in, cur[WIDTH-1:1]};
    end else begin
      res = {cur[WIDTH-2:0], bit_in};
    end
    return res;
  endfunction

  // Next-state, bit counter, shift register and load/error event decode.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    shift_s    = shift_r;
    load_s     = 1'b0;
    ferr_evt_s = 1'b0;
    if (step) begin
      case (state_r)
        IDLE: begin
          if (!serialIn) begin
            state_s = DATA;
            cnt_s   = '0;
          end else begin
            state_s = IDLE;
          end
        end
        DATA: begin
          shift_s = shift_in(shift_r, serialIn);
          if (cnt_r == LAST_BIT) begin
            state_s = STOP;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        STOP: begin
          state_s = IDLE;
          if (serialIn) begin
            load_s = 1'b1;
          end else begin
            ferr_evt_s = 1'b1;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Frame FSM state, bit counter and shift register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      shift_r <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      shift_r <= shift_s;
    end
  end

  // Output word, valid handshake and sticky error flags; events beat clears.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outData  <= '0;
      valid    <= 1'b0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (load_s) begin
        outData <= shift_r;
      end
      if (load_s) begin
        valid <= 1'b1;
      end else if (ack) begin
        valid <= 1'b0;
      end
      // A load acknowledged on the same edge is not an overrun.
      if (load_s && valid && !ack) begin
        overrun <= 1'b1;
      end else if (clrErr) begin
        overrun <= 1'b0;
      end
      if (ferr_evt_s) begin
        frameErr <= 1'b1;
      end else if (clrErr) begin
        frameErr <= 1'b0;
      end
    end
  end

  assign busy = (state_r != IDLE);

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameter WIDTH, default 4: data bits per frame; legal range 2..16.
REQ-002 Parameter LSB_FIRST, default 1: 1 = first received data bit lands in outData[0]; 0 = first bit lands in outData[WIDTH-1].
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 serialIn  input  1  serial line; idles high.
REQ-006 step  input  1  bit strobe; serialIn is sampled only on edges where step=1.
REQ-007 ack  input  1  consumer acknowledge; clears valid.
REQ-008 clrErr  input  1  clears the sticky error flags.
REQ-009 outData  output  WIDTH  last good received word.
REQ-010 valid  output  1  outData holds an unacknowledged word.
REQ-011 busy  output  1  FSM is not in IDLE.
REQ-012 frameErr  output  1  sticky: a stop bit was sampled low.
REQ-013 overrun  output  1  sticky: a word was overwritten before ack.

Function
REQ-014 The frame format SHALL be: 1 start bit (0), then WIDTH data bits, then 1 stop bit (1), with one bit per step strobe.
REQ-015 The FSM SHALL have three states: IDLE, DATA and STOP; busy=1 in DATA and STOP.
REQ-016 In IDLE, step=1 with serialIn=0 SHALL go to DATA with bit counter=0; step=1 with serialIn=1 SHALL stay in IDLE.
REQ-017 In DATA, each step SHALL shift serialIn into an internal shift register and increment the counter.
- LSB_FIRST=1: shift right, insert at MSB.
- LSB_FIRST=0: shift left, insert at LSB.
REQ-018 The step that captures data bit WIDTH-1 SHALL move the FSM to STOP.
REQ-019 In STOP, step with serialIn=1 SHALL copy the shift register to outData, set valid and return to IDLE.
REQ-020 In STOP, step with serialIn=0 SHALL set frameErr, leave outData and valid unchanged, and return to IDLE.
REQ-021 Cycles with step=0 SHALL hold all state, independent of serialIn.
REQ-022 Load latency: outData and valid SHALL update on the same edge that samples the stop bit.
REQ-023 ack=1 SHALL clear valid on the next edge, unless a load occurs on that edge.
REQ-024 Load on an edge with ack=1: valid stays 1 and overrun is not set.
REQ-025 Load while valid=1 and ack=0: outData is overwritten, valid stays 1, and overrun is set.
REQ-026 clrErr=1 SHALL clear frameErr and overrun on the next edge.
REQ-027 If an error event and clrErr occur on the same edge, the flag SHALL end set (event wins).
REQ-028 ack and clrErr SHALL NOT affect the FSM or the shift register.
REQ-029 The bit counter SHALL be wide enough for WIDTH-1 and SHALL never wrap within a frame.
REQ-030 There SHALL be no break or idle timeout detection; the line is checked only at start and stop bits.

Reset
REQ-031 reset=0 SHALL immediately force, regardless of clock, all of the following:
- FSM=IDLE, counter=0, shift register=0.
- outData=0, valid=0, busy=0, frameErr=0, overrun=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; no load and no error flag result.
REQ-033 After reset deasserts, the first edge SHALL behave as in IDLE.

Verification
REQ-034 Good frame, WIDTH=4, LSB_FIRST=1: steps carry 0,1,0,1,1,1 -> after the 6th step outData=4'b1101, valid=1, busy=0, frameErr=0.
REQ-035 Same data bits, LSB_FIRST=0 -> outData=4'b1011.
REQ-036 Bad stop: steps 0,1,1,1,1,0 -> frameErr=1, valid=0, outData=0; clrErr pulse -> frameErr=0.
REQ-037 Overrun: two good frames, 0x3 then 0xA, with no ack -> outData=0xA, valid=1, overrun=1.
- Repeat with ack=1 on the second stop-bit edge -> overrun=0, valid=1.
REQ-038 Reset mid-frame after 2 data bits, then a full good frame 0x6 -> outData=0x6, valid=1, no errors.
- Also check: step=0 for 10 cycles mid-frame while toggling serialIn -> no state change.
